score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Upstream of the 4-digit score display: accumulates the 11-bit binary game score from
//  food-eaten events and drives the display's score input. Adds a streak bonus for quick
//  successive eats, saturates at SCORE_MAX, and freezes the score at game over.
//  Sits between the snake game-logic FSM and the score display.
// PARAMETERS
//  POINTS_BASE  1      points per eat outside a streak
//  POINTS_BONUS 2      points per eat inside a streak
//  STREAK_WIN   8      game_ticks after an eat within which the next eat is a streak (1..255)
//  SCORE_MAX    1999   saturation ceiling (<= 2047)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  game_tick  in   1   1-cycle pulse per snake step
//  eat        in   1   level from game logic, high while head is on food; rising edge = one eat
//  game_start in   1   1-cycle pulse: begin new game
//  game_over  in   1   1-cycle pulse: snake died
//  score      out  11  current score, binary, registered
//  hiscore    out  11  best score since reset, registered
//  new_record out  1   high from game over that beat hiscore until next game_start
//  playing    out  1   high in PLAY state
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-high on rst.
//  - Reset: score=0, hiscore=0, new_record=0, playing=0, state=IDLE, eat_q=0, streak_cnt=STREAK_WIN.
//  - FSM: IDLE -game_start-> PLAY; PLAY -game_over-> OVER; OVER -game_start-> PLAY.
//    game_start in PLAY ignored; game_over in IDLE/OVER ignored.
//  - Entering PLAY: score<=0, streak_cnt<=STREAK_WIN (no streak), new_record<=0.
//  - eat_q registered every cycle; eat_edge = eat & ~eat_q. Edges counted only in PLAY.
//  - On eat_edge: pts = (streak_cnt < STREAK_WIN) ? POINTS_BONUS : POINTS_BASE;
//    score <= min(score + pts, SCORE_MAX), sum computed at 12 bits; streak_cnt <= 0.
//    Score visible on the cycle after the edge-detect cycle (1-cycle latency).
//  - On game_tick in PLAY without eat_edge: streak_cnt <= min(streak_cnt+1, STREAK_WIN).
//    eat_edge and game_tick same cycle: eat wins (streak_cnt<=0).
//  - eat_edge and game_over same cycle in PLAY: eat is scored, then state -> OVER.
//  - OVER/IDLE: score held (OVER frozen, IDLE 0); eat and game_tick ignored.
//  - eat held high across game_start produces no edge until eat falls and rises again.
//  - Reset mid-game: all state returns to reset values next cycle, no partial update.
// CONFIGURATION
//  - SCORE_HISCORE_EN defined: on PLAY->OVER, if final score (incl. same-cycle eat) > hiscore
//    then hiscore<=final score, new_record<=1. Equal score is not a record.
//  - Not defined: hiscore tied to 11'd0, new_record tied to 0, no hiscore register.
// STRUCTURE
//  - Shared package/header score_defs: SCORE_W=11, state encodings ST_IDLE=2'd0,
//    ST_PLAY=2'd1, ST_OVER=2'd2.
//  - One sub-module: rise_detect (registered rising-edge detector on eat).
// TESTING
//  1. rst high 2 cycles -> score=0, hiscore=0, playing=0, new_record=0.
//  2. game_start, 3 eats each 10 ticks apart -> score=3 (1+1+1).
//  3. game_start, eat, 3 ticks, eat, 2 ticks, eat -> score=5 (1+2+2); eat after 8 ticks -> +1.
//  4. score=1998, streak eat -> score=1999; further eats -> stays 1999.
//  5. eat and game_over same cycle at score=4 -> score=5 frozen, playing=0; later eats ignored;
//     with SCORE_HISCORE_EN hiscore=5, new_record=1; game_start -> score=0, new_record=0.
//  6. rst asserted mid-PLAY at score=7 -> score=0, state IDLE; eat held high over game_start -> no count.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared widths, FSM encodings and the saturating score adder for score_keeper.
package score_keeper_pkg;

  localparam int SCORE_W = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  // Sum at one extra bit so a carry out of 11 bits can never wrap below the ceiling.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b,
    input logic [SCORE_W-1:0] max
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: the sample register runs every cycle regardless of game state.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // previous-cycle sample of d
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/score_keeper.sv
// Game score accumulator with streak bonus and saturation; the hiscore/new_record
// tracking is built only when SCORE_HISCORE_EN is defined.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int POINTS_BASE  = 1,
  parameter int POINTS_BONUS = 2,
  parameter int STREAK_WIN   = 8,
  parameter int SCORE_MAX    = 1999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               eat,
  input  logic               game_start,
  input  logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore,
  output logic               new_record,
  output logic               playing
);

  localparam logic [7:0]         WIN   = 8'(STREAK_WIN);
  localparam logic [SCORE_W-1:0] BASE  = SCORE_W'(POINTS_BASE);
  localparam logic [SCORE_W-1:0] BONUS = SCORE_W'(POINTS_BONUS);
  localparam logic [SCORE_W-1:0] SMAX  = SCORE_W'(SCORE_MAX);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         streak_q, streak_d;
  logic               eat_edge;
  logic               enter_play;
  logic               finish;

  rise_detect u_eat_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (eat),
    .rise (eat_edge)
  );

  assign enter_play = game_start & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  assign finish     = game_over & (state_q == ST_PLAY);

  // next-state, score and streak counter
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (game_start) begin
          state_d  = ST_PLAY;
          score_d  = {SCORE_W{1'b0}};
          streak_d = WIN;
        end else begin
          state_d  = state_q;
        end
      end
      ST_PLAY: begin
        // a same-cycle eat takes priority over the tick and is scored before leaving PLAY
        if (eat_edge) begin
          score_d  = sat_add(score_q, (streak_q < WIN) ? BONUS : BASE, SMAX);
          streak_d = 8'd0;
        end else if (game_tick) begin
          streak_d = (streak_q < WIN) ? streak_q + 8'd1 : WIN;
        end else begin
          streak_d = streak_q;
        end
        if (game_over) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        score_d  = {SCORE_W{1'b0}};
        streak_d = WIN;
      end
    endcase
  end

  // main state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      score_q  <= {SCORE_W{1'b0}};
      streak_q <= WIN;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      streak_q <= streak_d;
    end
  end

  assign score   = score_q;
  assign playing = (state_q == ST_PLAY);

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
  logic               new_record_q;

  // best score is compared against the final score including any same-cycle eat
  always_ff @(posedge clk) begin
    if (rst) begin
      hiscore_q    <= {SCORE_W{1'b0}};
      new_record_q <= 1'b0;
    end else if (finish && (score_d > hiscore_q)) begin
      hiscore_q    <= score_d;
      new_record_q <= 1'b1;
    end else if (enter_play) begin
      new_record_q <= 1'b0;
    end else begin
      new_record_q <= new_record_q;
    end
  end

  assign hiscore    = hiscore_q;
  assign new_record = new_record_q;
`else
  logic unused_finish;
  assign unused_finish = finish ^ enter_play;
  assign hiscore       = {SCORE_W{1'b0}};
  assign new_record    = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Table-driven bench for score_keeper; hiscore expectations follow SCORE_HISCORE_EN.
module tb_score_keeper;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk;
  logic        rst, tick, eat, start, over;
  logic [10:0] score, hiscore;
  logic        nr, playing;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        r, s, o, t, e;
    logic [10:0] sc;
    logic        p;
    logic [10:0] hi;
    logic        nr;
  } vec_t;

  vec_t tbl[$];

  score_keeper dut (
    .clk        (clk),
    .rst        (rst),
    .game_tick  (tick),
    .eat        (eat),
    .game_start (start),
    .game_over  (over),
    .score      (score),
    .hiscore    (hiscore),
    .new_record (nr),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, s, o, t, e, input int sc, input logic p, input int hi,
                     input logic n);
    vec_t v;
    v.r = r; v.s = s; v.o = o; v.t = t; v.e = e;
    v.sc = 11'(sc); v.p = p;
    v.hi = HI_EN ? 11'(hi) : 11'd0;
    v.nr = HI_EN ? n : 1'b0;
    tbl.push_back(v);
  endtask

  task automatic ticks(input int n, input int sc, input logic p, input int hi, input logic nrv);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc, p, hi, nrv);
  endtask

  // eat pulse: rising cycle then low cycle, both expecting the post-eat score
  task automatic eatp(input int sc, input int hi);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sc, 1'b1, hi, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc, 1'b1, hi, 1'b0);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, s, o, t, e);
    rst = r; start = s; over = o; tick = t; eat = e;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eat();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; over = 1'b0; tick = 1'b0; eat = 1'b0;

    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // three spaced eats, base points only
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    eatp(1, 0); ticks(10, 1, 1, 0, 0);
    eatp(2, 0); ticks(10, 2, 1, 0, 0);
    eatp(3, 0);
    add(0, 0, 1, 0, 0, 3, 0, 3, 1);
    // streak bonus, window edges, eat beats tick
    add(0, 1, 0, 0, 0, 0, 1, 3, 0);
    eatp(1, 3);  ticks(3, 1, 1, 3, 0);
    eatp(3, 3);  ticks(2, 3, 1, 3, 0);
    eatp(5, 3);  ticks(8, 5, 1, 3, 0);
    eatp(6, 3);  ticks(7, 6, 1, 3, 0);
    eatp(8, 3);
    add(0, 0, 0, 1, 1, 10, 1, 3, 0);
    add(0, 0, 0, 0, 0, 10, 1, 3, 0);
    ticks(7, 10, 1, 3, 0);
    eatp(12, 3);
    add(0, 0, 1, 0, 0, 12, 0, 12, 1);
    add(0, 0, 0, 0, 1, 12, 0, 12, 1);
    add(0, 0, 0, 0, 0, 12, 0, 12, 1);
    // eat with game_over, frozen score, equal score is no record
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    eatp(1, 0); eatp(3, 0); ticks(8, 3, 1, 0, 0);
    eatp(4, 0); ticks(8, 4, 1, 0, 0);
    add(0, 0, 1, 0, 1, 5, 0, 5, 1);
    add(0, 0, 0, 0, 0, 5, 0, 5, 1);
    add(0, 0, 0, 0, 1, 5, 0, 5, 1);
    add(0, 0, 0, 1, 0, 5, 0, 5, 1);
    add(0, 1, 0, 0, 0, 0, 1, 5, 0);
    eatp(1, 5); eatp(3, 5); eatp(5, 5);
    add(0, 0, 1, 0, 0, 5, 0, 5, 0);
    // reset mid-game with eat held high, then no edge across game_start
    add(0, 1, 0, 0, 0, 0, 1, 5, 0);
    eatp(1, 5); eatp(3, 5); eatp(5, 5);
    add(0, 0, 0, 0, 1, 7, 1, 5, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].o, tbl[i].t, tbl[i].e);
      chk("score", i, int'(score), int'(tbl[i].sc));
      chk("playing", i, int'(playing), int'(tbl[i].p));
      chk("hiscore", i, int'(hiscore), int'(tbl[i].hi));
      chk("new_record", i, int'(nr), int'(tbl[i].nr));
    end

    // saturation at the ceiling
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_eat();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_eat();
    for (int i = 0; i < 998; i++) pulse_eat();
    chk("sat_pre", 0, int'(score), 1998);
    pulse_eat();
    chk("sat_hit", 0, int'(score), 1999);
    pulse_eat();
    pulse_eat();
    chk("sat_hold", 0, int'(score), 1999);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_eat();
    chk("sat_base", 0, int'(score), 1999);
    chk("sat_play", 0, int'(playing), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
